// File: rtl/regfile_pkg.sv
// Shared helpers for the scoreboarded register file: width calculation
// and bit offsets of the packed per-port select and data buses.
package regfile_pkg;

    // Bits needed to encode values 0..value-1 (0 for value <= 1).
    function automatic int clog2(input int value);
        int w;
        int v;
        w = 0;
        v = value - 1;
        while (v > 0) begin
            w = w + 1;
            v = v >> 1;
        end
        return w;
    endfunction

    // LSB of read port `port` inside the packed select bus.
    function automatic int sel_lsb(input int port, input int addr_w);
        return port * addr_w;
    endfunction

    // LSB of read port `port` inside the packed read-data bus.
    function automatic int data_lsb(input int port, input int data_w);
        return port * data_w;
    endfunction

endpackage

// File: rtl/regfile_core.sv
// Architectural register array: one write port and NUM_RD read ports,
// each read port bypassing the same-cycle writeback value.
module regfile_core
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    parameter int NUM_RD   = 2,
    parameter int ADDR_W   = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_sel,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_sel,
    input  logic [DATA_W-1:0]        wr_data
);

    logic [DATA_W-1:0] mem [NUM_REGS];

    // Register array: cleared on reset, written on every writeback.
    // NOTE: the array is reset because readers rely on it reading zero after
    // rst; state is updated with <= so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                mem[r] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_sel] <= wr_data;
        end
    end

    // Read ports: writeback data wins over the stored value on a select match.
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] sel;
        assign sel = rd_sel[sel_lsb(i, ADDR_W) +: ADDR_W];
        assign rd_data[data_lsb(i, DATA_W) +: DATA_W] =
            (wr_en && wr_sel == sel) ? wr_data : mem[sel];
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Decode-stage register file with per-register pending-write counters.
// Stalls issue on unresolved source hazards or a saturated destination
// counter; writeback retires pending writes, flush clears them all.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int DATA_W   = 16,
    parameter  int NUM_REGS = 8,
    parameter  int NUM_RD   = 2,
    parameter  int MAX_PEND = 3,
    localparam int ADDR_W   = clog2(NUM_REGS),
    localparam int PEND_W   = clog2(MAX_PEND + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_sel,
    input  logic [NUM_RD-1:0]        rd_use,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     issue_valid,
    input  logic                     issue_wr_en,
    input  logic [ADDR_W-1:0]        issue_wr_sel,
    output logic                     stall,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_sel,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     flush,
    output logic [NUM_REGS-1:0]      busy,
    output logic                     err
);

    logic [PEND_W-1:0] pending [NUM_REGS];
    logic [ADDR_W-1:0] src_sel [NUM_RD];
    logic [NUM_REGS-1:0] inc_vec;
    logic [NUM_REGS-1:0] dec_vec;
    logic src_hazard;
    logic dest_sat;
    logic issue_fire;

    regfile_core #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .NUM_RD   (NUM_RD),
        .ADDR_W   (ADDR_W)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .rd_sel  (rd_sel),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_sel  (wr_sel),
        .wr_data (wr_data)
    );

    for (genvar i = 0; i < NUM_RD; i++) begin : g_src
        assign src_sel[i] = rd_sel[sel_lsb(i, ADDR_W) +: ADDR_W];
    end

    // Source hazard: a used operand has writes in flight, unless its last
    // pending write is retiring right now and the bypass supplies it.
    // NOTE: src_hazard is given a default before the loop so every path
    // assigns it and no latch is inferred.
    always_comb begin
        src_hazard = 1'b0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (rd_use[i] && pending[src_sel[i]] != '0 &&
                !(pending[src_sel[i]] == PEND_W'(1) && wr_en && wr_sel == src_sel[i])) begin
                src_hazard = 1'b1;
            end
        end
    end

    // A full destination counter only blocks issue if it is not draining now.
    assign dest_sat = issue_wr_en
                   && pending[issue_wr_sel] == PEND_W'(MAX_PEND)
                   && !(wr_en && wr_sel == issue_wr_sel);

    assign stall      = issue_valid && (src_hazard || dest_sat);
    assign issue_fire = issue_valid && !stall && !flush;

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
        assign inc_vec[r] = issue_fire && issue_wr_en && issue_wr_sel == ADDR_W'(r);
        assign dec_vec[r] = wr_en && wr_sel == ADDR_W'(r) && pending[r] != '0;
        assign busy[r]    = pending[r] != '0;
    end

    // Pending counters: +1 per accepted issue, -1 per retiring writeback.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                pending[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                case ({inc_vec[r], dec_vec[r]})
                    2'b10:   pending[r] <= pending[r] + PEND_W'(1);
                    2'b01:   pending[r] <= pending[r] - PEND_W'(1);
                    default: pending[r] <= pending[r];
                endcase
            end
        end
    end

    // Sticky error on a writeback to a register with nothing pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (wr_en && !flush && pending[wr_sel] == '0) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard (three read ports). Directed
// scenarios plus a randomized run compared against an array/counter model.
module tb_regfile_scoreboard;

    localparam int DW   = 16;
    localparam int NREG = 8;
    localparam int NRD  = 3;
    localparam int MAXP = 3;
    localparam int AW   = 3;

    logic            clk;
    logic            rst;
    logic [NRD*AW-1:0] rd_sel;
    logic [NRD-1:0]  rd_use;
    logic [NRD*DW-1:0] rd_data;
    logic            issue_valid;
    logic            issue_wr_en;
    logic [AW-1:0]   issue_wr_sel;
    logic            stall;
    logic            wr_en;
    logic [AW-1:0]   wr_sel;
    logic [DW-1:0]   wr_data;
    logic            flush;
    logic [NREG-1:0] busy;
    logic            err;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [DW-1:0] m_mem [NREG];
    int            m_pend [NREG];
    bit            m_err;

    regfile_scoreboard #(
        .DATA_W   (DW),
        .NUM_REGS (NREG),
        .NUM_RD   (NRD),
        .MAX_PEND (MAXP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rd_sel       (rd_sel),
        .rd_use       (rd_use),
        .rd_data      (rd_data),
        .issue_valid  (issue_valid),
        .issue_wr_en  (issue_wr_en),
        .issue_wr_sel (issue_wr_sel),
        .stall        (stall),
        .wr_en        (wr_en),
        .wr_sel       (wr_sel),
        .wr_data      (wr_data),
        .flush        (flush),
        .busy         (busy),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [DW-1:0] m_rd(input int i);
        int s;
        s = int'(rd_sel[i*AW +: AW]);
        if (wr_en && int'(wr_sel) == s) return wr_data;
        return m_mem[s];
    endfunction

    function automatic bit m_stall();
        bit hz;
        int s;
        int d;
        hz = 0;
        for (int i = 0; i < NRD; i++) begin
            s = int'(rd_sel[i*AW +: AW]);
            if (rd_use[i] && m_pend[s] > 0 &&
                !(m_pend[s] == 1 && wr_en && int'(wr_sel) == s)) hz = 1;
        end
        d = int'(issue_wr_sel);
        if (issue_wr_en && m_pend[d] >= MAXP && !(wr_en && int'(wr_sel) == d)) hz = 1;
        return issue_valid && hz;
    endfunction

    function automatic logic [NREG-1:0] m_busy();
        logic [NREG-1:0] b;
        for (int r = 0; r < NREG; r++) b[r] = (m_pend[r] != 0);
        return b;
    endfunction

    // Advance one clock: fold current inputs into the model, then step DUT.
    task automatic tick();
        bit fire;
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                m_mem[r] = '0;
                m_pend[r] = 0;
            end
            m_err = 0;
        end else begin
            fire = issue_valid && !m_stall() && !flush;
            if (wr_en && !flush && m_pend[wr_sel] == 0) m_err = 1;
            if (flush) begin
                for (int r = 0; r < NREG; r++) m_pend[r] = 0;
            end else begin
                if (wr_en && m_pend[wr_sel] > 0) m_pend[wr_sel] = m_pend[wr_sel] - 1;
                if (fire && issue_wr_en) m_pend[issue_wr_sel] = m_pend[issue_wr_sel] + 1;
            end
            if (wr_en) m_mem[wr_sel] = wr_data;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rd_sel = '0; rd_use = '0;
        issue_valid = 0; issue_wr_en = 0; issue_wr_sel = '0;
        wr_en = 0; wr_sel = '0; wr_data = '0; flush = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic issue_to(input int r);
        issue_valid = 1; issue_wr_en = 1; issue_wr_sel = AW'(r);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        rd_sel[0*AW +: AW] = 3'd3;
        rd_sel[1*AW +: AW] = 3'd5;
        #1;
        for (int i = 0; i < NRD; i++) begin
            total++;
            if (rd_data[i*DW +: DW] !== 16'h0) begin
                bad++; $display("FAIL reset_rd port=%0d got=%h exp=0000", i, rd_data[i*DW +: DW]);
            end
        end
        total++; if (busy !== 8'h00) begin bad++; $display("FAIL reset_busy got=%h exp=00", busy); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
        tick();
    endtask

    task automatic test_bypass();
        do_reset();
        wr_en = 1; wr_sel = 3'd3; wr_data = 16'hBEEF;
        rd_sel[0*AW +: AW] = 3'd3;
        rd_sel[1*AW +: AW] = 3'd1;
        #1;
        total++; if (rd_data[0 +: DW] !== 16'hBEEF) begin bad++; $display("FAIL bypass_same got=%h exp=beef", rd_data[0 +: DW]); end
        total++; if (rd_data[DW +: DW] !== 16'h0) begin bad++; $display("FAIL bypass_other got=%h exp=0000", rd_data[DW +: DW]); end
        tick();
        wr_en = 0;
        for (int k = 0; k < 2; k++) begin
            #1;
            total++; if (rd_data[0 +: DW] !== 16'hBEEF) begin bad++; $display("FAIL bypass_hold k=%0d got=%h exp=beef", k, rd_data[0 +: DW]); end
            tick();
        end
        // The write had no pending issue behind it, so it is an underflow.
        total++; if (err !== 1'b1) begin bad++; $display("FAIL bypass_err got=%b exp=1", err); end
    endtask

    task automatic test_raw_stall();
        logic [DW-1:0] d;
        do_reset();
        issue_to(2);
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL raw_issue_stall got=%b exp=0", stall); end
        tick();
        total++; if (busy[2] !== 1'b1) begin bad++; $display("FAIL raw_busy got=%b exp=1", busy[2]); end
        issue_wr_en = 0; rd_use = 3'b001; rd_sel[0 +: AW] = 3'd2;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++; if (stall !== 1'b1) begin bad++; $display("FAIL raw_hold k=%0d got=%b exp=1", k, stall); end
            tick();
        end
        d = 16'($urandom);
        wr_en = 1; wr_sel = 3'd2; wr_data = d;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL raw_release got=%b exp=0", stall); end
        total++; if (rd_data[0 +: DW] !== d) begin bad++; $display("FAIL raw_bypass got=%h exp=%h", rd_data[0 +: DW], d); end
        tick();
        idle_inputs();
        #1;
        total++; if (busy !== 8'h00) begin bad++; $display("FAIL raw_retired got=%h exp=00", busy); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL raw_err got=%b exp=0", err); end
    endtask

    task automatic test_saturation();
        do_reset();
        issue_to(4);
        for (int k = 0; k < 3; k++) begin
            #1;
            total++; if (stall !== 1'b0) begin bad++; $display("FAIL sat_fill k=%0d got=%b exp=0", k, stall); end
            tick();
        end
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL sat_fourth got=%b exp=1", stall); end
        tick();
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL sat_still got=%b exp=1", stall); end
        wr_en = 1; wr_sel = 3'd4; wr_data = 16'h1234;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL sat_retire got=%b exp=0", stall); end
        tick();
        wr_en = 0;
        #1;
        // Counter is back at three, so another issue to r4 must stall.
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL sat_kept got=%b exp=1", stall); end
        total++; if (busy !== 8'h10) begin bad++; $display("FAIL sat_busy got=%h exp=10", busy); end
        idle_inputs();
        tick();
    endtask

    task automatic test_underflow();
        do_reset();
        wr_en = 1; wr_sel = 3'd6; wr_data = 16'h0066;
        tick();
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            #1;
            total++; if (err !== 1'b1) begin bad++; $display("FAIL underflow_err k=%0d got=%b exp=1", k, err); end
            tick();
        end
        total++; if (busy !== 8'h00) begin bad++; $display("FAIL underflow_busy got=%h exp=00", busy); end
    endtask

    task automatic test_flush();
        do_reset();
        issue_to(1); tick();
        issue_to(5); tick();
        #1;
        total++; if (busy !== 8'h22) begin bad++; $display("FAIL flush_pre got=%h exp=22", busy); end
        flush = 1; issue_to(0);
        wr_en = 1; wr_sel = 3'd7; wr_data = 16'h7777;
        tick();
        idle_inputs();
        #1;
        total++; if (busy !== 8'h00) begin bad++; $display("FAIL flush_busy got=%h exp=00", busy); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL flush_err got=%b exp=0", err); end
        rd_sel[0 +: AW] = 3'd7;
        #1;
        total++; if (rd_data[0 +: DW] !== 16'h7777) begin bad++; $display("FAIL flush_write got=%h exp=7777", rd_data[0 +: DW]); end
        tick();
    endtask

    task automatic test_multiport();
        do_reset();
        issue_to(7); tick();
        issue_wr_en = 0;
        for (int i = 0; i < NRD; i++) rd_sel[i*AW +: AW] = 3'd7;
        rd_use = 3'b100;
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL multi_port2 got=%b exp=1", stall); end
        rd_use = 3'b000;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL multi_none got=%b exp=0", stall); end
        idle_inputs();
        tick();
    endtask

    task automatic test_random();
        int q[$];
        do_reset();
        for (int k = 0; k < 400; k++) begin
            rd_sel       = NRD*AW'($urandom);
            rd_use       = NRD'($urandom);
            issue_valid  = ($urandom_range(0, 3) != 0);
            issue_wr_en  = $urandom_range(0, 1);
            issue_wr_sel = AW'($urandom_range(0, 3));
            flush        = ($urandom_range(0, 31) == 0);
            q.delete();
            for (int r = 0; r < NREG; r++) if (m_pend[r] > 0) q.push_back(r);
            wr_en = (q.size() > 0) && ($urandom_range(0, 2) == 0);
            wr_sel = (q.size() > 0) ? AW'(q[$urandom_range(0, q.size() - 1)]) : '0;
            wr_data = DW'($urandom);
            #1;
            for (int i = 0; i < NRD; i++) begin
                total++;
                if (rd_data[i*DW +: DW] !== m_rd(i)) begin
                    bad++; $display("FAIL rand_rd k=%0d port=%0d got=%h exp=%h", k, i, rd_data[i*DW +: DW], m_rd(i));
                end
            end
            total++; if (stall !== m_stall()) begin bad++; $display("FAIL rand_stall k=%0d got=%b exp=%b", k, stall, m_stall()); end
            total++; if (busy !== m_busy()) begin bad++; $display("FAIL rand_busy k=%0d got=%h exp=%h", k, busy, m_busy()); end
            total++; if (err !== m_err) begin bad++; $display("FAIL rand_err k=%0d got=%b exp=%b", k, err, m_err); end
            tick();
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_bypass();
        test_raw_stall();
        test_saturation();
        test_underflow();
        test_flush();
        test_multiport();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
